// File: rtl/alu_operand_loader.sv
// Purpose: sequences OP1, OP2 and OPCODE loads from a shared switch bus via one load button, then registers the ALU result.
// Latency: a load lands 2 edges after the button is first sampled high; the result registers on the EXEC cycle after the opcode load.
// Backpressure: none; a press seen while in EXEC is dropped, never queued.
module alu_operand_loader #(
  parameter int DATA_BUS   = 8,
  parameter int OPCODE_BUS = 6
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_BUS-1:0]   SW,
  input  logic                  BTN_LOAD,
  input  logic [DATA_BUS-1:0]   ALU_OUT,
  output logic [DATA_BUS-1:0]   OP1,
  output logic [DATA_BUS-1:0]   OP2,
  output logic [OPCODE_BUS-1:0] OPCODE,
  output logic [DATA_BUS-1:0]   RESULT,
  output logic                  RESULT_VALID,
  output logic                  ERR,
  output logic [1:0]            STATE
);

  typedef enum logic [1:0] {
    W_OP1 = 2'b00,
    W_OP2 = 2'b01,
    W_OPC = 2'b10,
    EXEC  = 2'b11
  } state_t;

  localparam logic [OPCODE_BUS-1:0] OPC_ADD = OPCODE_BUS'(6'b100000);
  localparam logic [OPCODE_BUS-1:0] OPC_SUB = OPCODE_BUS'(6'b100010);
  localparam logic [OPCODE_BUS-1:0] OPC_AND = OPCODE_BUS'(6'b100100);
  localparam logic [OPCODE_BUS-1:0] OPC_OR  = OPCODE_BUS'(6'b100101);
  localparam logic [OPCODE_BUS-1:0] OPC_XOR = OPCODE_BUS'(6'b100110);
  localparam logic [OPCODE_BUS-1:0] OPC_SRA = OPCODE_BUS'(6'b000011);
  localparam logic [OPCODE_BUS-1:0] OPC_SRL = OPCODE_BUS'(6'b000010);
  localparam logic [OPCODE_BUS-1:0] OPC_NOR = OPCODE_BUS'(6'b100111);

  state_t state;
  logic   btn_s1;
  logic   btn_s2;
  logic   btn_d;
  logic   ld;
  logic   opc_legal;

  // Bring the raw button into the clock domain and keep one cycle of history for rising-edge detection.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      btn_s1 <= 1'b0;
      btn_s2 <= 1'b0;
      btn_d  <= 1'b0;
    end else begin
      btn_s1 <= BTN_LOAD;
      btn_s2 <= btn_s1;
      btn_d  <= btn_s2;
    end
  end

  // One-cycle load strobe per press; holding the button never repeats it, bounce shows up as extra presses.
  assign ld = btn_s2 & ~btn_d;

  // Decode whether the registered opcode is one the ALU implements.
  always_comb begin
    opc_legal = 1'b0;
    case (OPCODE)
      OPC_ADD, OPC_SUB, OPC_AND, OPC_OR,
      OPC_XOR, OPC_SRA, OPC_SRL, OPC_NOR: opc_legal = 1'b1;
      default:                            opc_legal = 1'b0;
    endcase
  end

  // Load sequencer: each strobe fills the next field, then one EXEC cycle captures the ALU result or flags the opcode.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state        <= W_OP1;
      OP1          <= '0;
      OP2          <= '0;
      OPCODE       <= '0;
      RESULT       <= '0;
      RESULT_VALID <= 1'b0;
      ERR          <= 1'b0;
    end else begin
      case (state)
        W_OP1: begin
          if (ld) begin
            OP1          <= SW;
            RESULT_VALID <= 1'b0;
            ERR          <= 1'b0;
            state        <= W_OP2;
          end
        end
        W_OP2: begin
          if (ld) begin
            OP2   <= SW;
            state <= W_OPC;
          end
        end
        W_OPC: begin
          if (ld) begin
            OPCODE <= SW[OPCODE_BUS-1:0];
            state  <= EXEC;
          end
        end
        EXEC: begin
          // The ALU has had a full cycle to settle on the new operand set; an illegal opcode keeps the old result.
          if (opc_legal) begin
            RESULT       <= ALU_OUT;
            RESULT_VALID <= 1'b1;
          end else begin
            RESULT_VALID <= 1'b0;
            ERR          <= 1'b1;
          end
          state <= W_OP1;
        end
      endcase
    end
  end

  assign STATE = state;

endmodule

// File: tb/tb_alu_operand_loader.sv
// Purpose: randomized self-checking bench for alu_operand_loader with an ALU model and result scoreboard.
// Latency: expectations are pushed when the opcode press is issued and popped when the DUT leaves EXEC.
// Backpressure: none; presses are spaced so the button history clears between them.
module tb_alu_operand_loader;

  logic       CLK = 1'b0;
  logic       RST;
  logic [7:0] SW;
  logic       BTN_LOAD;
  logic [7:0] alu_out;
  logic [7:0] op1;
  logic [7:0] op2;
  logic [5:0] opcode;
  logic [7:0] result;
  logic       result_valid;
  logic       err;
  logic [1:0] state;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [7:0] res;
    logic       vld;
    logic       err;
    logic [7:0] a;
    logic [7:0] b;
    logic [5:0] opc;
  } exp_t;

  exp_t       sb_q[$];
  logic [7:0] model_result;
  logic [5:0] legal_list[8] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101,
                                6'b100110, 6'b000011, 6'b000010, 6'b100111};

  alu_operand_loader #(.DATA_BUS(8), .OPCODE_BUS(6)) dut (
    .CLK          (CLK),
    .RST          (RST),
    .SW           (SW),
    .BTN_LOAD     (BTN_LOAD),
    .ALU_OUT      (alu_out),
    .OP1          (op1),
    .OP2          (op2),
    .OPCODE       (opcode),
    .RESULT       (result),
    .RESULT_VALID (result_valid),
    .ERR          (err),
    .STATE        (state)
  );

  always #5 CLK = ~CLK;

  // Behavioural combinational ALU; unknown opcodes yield a marker value that must never be captured.
  function automatic logic [7:0] alu_ref(input logic [7:0] a, input logic [7:0] b, input logic [5:0] opc);
    logic signed [7:0] sa;
    sa = a;
    case (opc)
      6'b100000: return a + b;
      6'b100010: return a - b;
      6'b100100: return a & b;
      6'b100101: return a | b;
      6'b100110: return a ^ b;
      6'b000011: return sa >>> b[2:0];
      6'b000010: return a >> b[2:0];
      6'b100111: return ~(a | b);
      default:   return 8'hEE;
    endcase
  endfunction

  function automatic logic is_legal(input logic [5:0] opc);
    foreach (legal_list[i]) if (legal_list[i] == opc) return 1'b1;
    return 1'b0;
  endfunction

  assign alu_out = alu_ref(op1, op2, opcode);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every EXEC -> W_OP1 transition retires one operation from the scoreboard.
  logic [1:0] prev_state = 2'b00;
  always @(negedge CLK) begin
    exp_t e;
    if (RST) begin
      prev_state = 2'b00;
    end else begin
      if (prev_state == 2'b11 && state == 2'b00) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected: result %0h with empty queue", result);
        end else begin
          e = sb_q.pop_front();
          chk("sb_result", result, e.res);
          chk("sb_valid", result_valid, e.vld);
          chk("sb_err", err, e.err);
          chk("sb_op1", op1, e.a);
          chk("sb_op2", op2, e.b);
          chk("sb_opcode", opcode, e.opc);
        end
      end
      prev_state = state;
    end
  end

  // One press: the field must change exactly at the second edge after first sampling, and only once per press.
  task automatic press(input logic [7:0] v, input int hold);
    logic [1:0] st0;
    logic [1:0] exp_st;
    @(negedge CLK);
    SW = v;
    BTN_LOAD = 1'b1;
    st0 = state;
    exp_st = st0 + 2'd1;
    @(negedge CLK);
    @(negedge CLK);
    chk("state_before_k2", state, st0);
    @(negedge CLK);
    chk("state_at_k2", state, exp_st);
    case (st0)
      2'd0: begin
        chk("op1_at_k2", op1, v);
        chk("valid_clr_at_k2", result_valid, 1'b0);
        chk("err_clr_at_k2", err, 1'b0);
        chk("result_hold_at_k2", result, model_result);
      end
      2'd1: chk("op2_at_k2", op2, v);
      2'd2: chk("opcode_at_k2", opcode, v[5:0]);
      default: ;
    endcase
    for (int i = 3; i < hold; i++) begin
      SW = 8'($urandom);
      @(negedge CLK);
    end
    if (hold > 3 && st0 != 2'd2) chk("no_reload_while_held", state, exp_st);
    BTN_LOAD = 1'b0;
    SW = 8'($urandom);
    repeat (4) @(negedge CLK);
    case (st0)
      2'd0: chk("op1_held", op1, v);
      2'd1: chk("op2_held", op2, v);
      2'd2: chk("opcode_held", opcode, v[5:0]);
      default: ;
    endcase
  endtask

  task automatic push_expect(input logic [7:0] a, input logic [7:0] b, input logic [5:0] opc);
    exp_t e;
    e.a = a;
    e.b = b;
    e.opc = opc;
    if (is_legal(opc)) begin
      model_result = alu_ref(a, b, opc);
      e.vld = 1'b1;
      e.err = 1'b0;
    end else begin
      e.vld = 1'b0;
      e.err = 1'b1;
    end
    e.res = model_result;
    sb_q.push_back(e);
  endtask

  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [7:0] opc_sw, input int hold);
    press(a, hold);
    press(b, hold);
    push_expect(a, b, opc_sw[5:0]);
    press(opc_sw, hold);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_op1"}, op1, 8'h00);
    chk({tag, "_op2"}, op2, 8'h00);
    chk({tag, "_opcode"}, opcode, 6'h00);
    chk({tag, "_result"}, result, 8'h00);
    chk({tag, "_valid"}, result_valid, 1'b0);
    chk({tag, "_err"}, err, 1'b0);
    chk({tag, "_state"}, state, 2'b00);
  endtask

  // Watchdog so the run always terminates.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] o;
    logic [7:0] r;
    RST = 1'b1;
    SW = 8'h00;
    BTN_LOAD = 1'b0;
    model_result = 8'h00;
    repeat (3) @(negedge CLK);
    check_reset_outputs("por");
    RST = 1'b0;
    repeat (2) @(negedge CLK);

    // Reset asserted mid-operation while waiting for the opcode; takes effect without a clock edge.
    press(8'h05, 3);
    press(8'h03, 3);
    chk("pre_reset_state", state, 2'b10);
    @(negedge CLK);
    #2 RST = 1'b1;
    #1 check_reset_outputs("async_rst");
    @(negedge CLK);
    RST = 1'b0;
    model_result = 8'h00;
    repeat (2) @(negedge CLK);

    // ADD 5 + 3.
    run_op(8'h05, 8'h03, 8'h20, 3);
    // Illegal opcode after a good result: old result is retained.
    run_op(8'h11, 8'h22, 8'h3F, 3);
    chk("illegal_keeps_result", result, 8'h08);
    // NOR with the opcode coming from the low six switches.
    run_op(8'hF0, 8'h0F, 8'h27, 3);
    chk("nor_opcode", opcode, 6'b100111);

    // Button held for 50 cycles with the switches toggling: exactly one OP1 load.
    a = 8'h5A;
    press(a, 50);
    chk("held_state", state, 2'b01);
    chk("held_op1", op1, a);
    b = 8'h13;
    press(b, 3);
    push_expect(a, b, 6'b100010);
    press(8'h22, 3);

    // Randomized operations, half drawn from the legal set.
    for (int n = 0; n < 25; n++) begin
      a = 8'($urandom);
      b = 8'($urandom);
      r = 8'($urandom);
      if ($urandom_range(0, 1) == 1) o = {r[7:6], legal_list[$urandom_range(0, 7)]};
      else o = r;
      run_op(a, b, o, int'($urandom_range(3, 8)));
    end

    repeat (5) @(negedge CLK);
    chk("sb_drained", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
